// File: rtl/seq_alu.sv
// Registered ALU with a start/done handshake. Logic and add/sub/slt ops finish in
// one cycle. Unsigned multiply (shift-add) and divide (restoring) take WIDTH steps.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             overflow,
  output logic             zero,
  output logic             err,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc;   // product high half / partial remainder
  logic [WIDTH-1:0] lo;    // multiplier -> product low half / dividend -> quotient
  logic [WIDTH-1:0] opb;   // multiplicand / divisor
  logic             last;

  assign last = (count == CW'(WIDTH - 1));
  assign busy = (state != IDLE);

  // Single-cycle datapath, evaluated straight from the input operands.
  logic [WIDTH-1:0] sum, diff, sc_result;
  logic             add_ovf, sub_ovf, sc_ovf, sc_err;

  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    sc_result = '0;
    sc_ovf    = 1'b0;
    sc_err    = 1'b0;
    case (control)
      OP_ADD:  begin sc_result = sum;  sc_ovf = add_ovf; end
      OP_SUB:  begin sc_result = diff; sc_ovf = sub_ovf; end
      OP_AND:  sc_result = a & b;
      OP_OR:   sc_result = a | b;
      OP_NOR:  sc_result = ~(a | b);
      OP_NAND: sc_result = ~(a & b);
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
      OP_MUL, OP_DIV: ;
      default: sc_err = 1'b1;
    endcase
  end

  // One shift-add multiply step on the multiplier LSB.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc_next, mul_lo_next;

  assign mul_sum      = {1'b0, acc} + (lo[0] ? {1'b0, opb} : '0);
  assign mul_acc_next = mul_sum[WIDTH:1];
  assign mul_lo_next  = {mul_sum[0], lo[WIDTH-1:1]};

  // One restoring divide step; the compare uses the bit shifted out of acc so a
  // zero divisor (remainder unbounded) still yields all-ones quotient and rem = a.
  logic [WIDTH-1:0] div_shift, div_acc_next, div_lo_next;
  logic             div_ok;

  assign div_shift    = {acc[WIDTH-2:0], lo[WIDTH-1]};
  assign div_ok       = {acc, lo[WIDTH-1]} >= {1'b0, opb};
  assign div_acc_next = div_ok ? div_shift - opb : div_shift;
  assign div_lo_next  = {lo[WIDTH-2:0], div_ok};

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) begin
        if (control == OP_MUL)      state_next = MUL;
        else if (control == OP_DIV) state_next = DIV;
      end
      MUL, DIV: if (last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      result_hi <= '0;
      overflow  <= 1'b0;
      zero      <= 1'b1;
      err       <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
      acc       <= '0;
      lo        <= '0;
      opb       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          count <= '0;
          acc   <= '0;
          if (control == OP_MUL) begin
            lo  <= b;
            opb <= a;
          end else if (control == OP_DIV) begin
            lo  <= a;
            opb <= b;
          end else begin
            result    <= sc_result;
            result_hi <= '0;
            overflow  <= sc_ovf;
            zero      <= (sc_result == '0);
            err       <= sc_err;
            done      <= 1'b1;
          end
        end
        MUL: begin
          acc   <= mul_acc_next;
          lo    <= mul_lo_next;
          count <= count + CW'(1);
          if (last) begin
            result    <= mul_lo_next;
            result_hi <= mul_acc_next;
            overflow  <= 1'b0;
            zero      <= (mul_lo_next == '0);
            err       <= 1'b0;
            done      <= 1'b1;
          end
        end
        DIV: begin
          acc   <= div_acc_next;
          lo    <= div_lo_next;
          count <= count + CW'(1);
          if (last) begin
            result    <= div_lo_next;
            result_hi <= div_acc_next;
            overflow  <= 1'b0;
            zero      <= (div_lo_next == '0);
            err       <= (opb == '0);
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU with a start/done handshake. It executes the existing single-cycle operation set (add, sub, and, or, nor, nand, slt) and adds multi-cycle unsigned multiply and divide, built as shift-add and restoring iterations. It sits between the register-file read ports and the write-back mux. Multi-cycle operations hold `busy` so the controller can stall.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 4.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request; sampled only when `busy`=0.
- `control` in 4: operation select (codes below).
- `a` in WIDTH: operand A; captured on the accepted `start`.
- `b` in WIDTH: operand B; captured on the accepted `start`.
- `result` out WIDTH: primary result (sum, logic result, slt result, product low half, quotient).
- `result_hi` out WIDTH: product high half or remainder; 0 for single-cycle ops.
- `overflow` out 1: signed overflow, add/sub only; 0 for all other ops.
- `zero` out 1: 1 when `result` equals 0.
- `err` out 1: 1 for an illegal `control` code or a divide by zero.
- `busy` out 1: 1 while a multi-cycle op is in progress.
- `done` out 1: one-cycle pulse; all outputs are valid in that cycle.

## Operation
Control codes:
- 0010 add, 0110 sub, 0000 and, 0001 or, 1100 nor, 1101 nand, 0111 slt.
- 1000 mul, unsigned: {`result_hi`,`result`} = `a`×`b`, 2·WIDTH bits.
- 1001 div, unsigned: `result` = `a`/`b`, `result_hi` = `a`%`b`.
- Any other code is illegal: `result`=0, `result_hi`=0, `err`=1, completes as a single-cycle op.

Add/sub:
- Arithmetic is modulo 2^WIDTH.
- `overflow` = operand signs (B inverted for sub) are equal and the result sign differs.

Slt:
- `result` = {WIDTH-1 zeros, (a <signed b)}.
- The comparison is correct even when a−b overflows, i.e. it uses sign XOR overflow, not the raw sign bit.
- `overflow` = 0.

Divide by zero:
- `result` = all ones, `result_hi` = `a`, `err`=1.
- Still takes the full WIDTH iterations.

State machine, states IDLE, MUL, DIV:
- IDLE: on `start`, latch `a`, `b`, `control`.
  - Single-cycle or illegal code: write outputs, pulse `done`, stay in IDLE.
  - mul: clear accumulator and iteration counter, go to MUL.
  - div: clear accumulator and iteration counter, go to DIV.
- MUL: one shift-add step per cycle on the LSB of the multiplier.
- DIV: one restore step per cycle, processing dividend bits MSB first.
- Counter: width ⌈log2 WIDTH⌉+1. In MUL or DIV, when the counter reaches WIDTH−1, that cycle's edge writes `result`/`result_hi`/`zero`/`err`, pulses `done`, and returns to IDLE.
- `start` while `busy`=1 is ignored: no queueing, no effect on the op in progress.
- Operand changes after acceptance have no effect.

Output retention:
- `result`, `result_hi`, `overflow`, `zero`, `err` hold their values until the next completion.
- They do not change during MUL/DIV; intermediate values stay internal.

## Timing
- Reset values: `result`=0, `result_hi`=0, `overflow`=0, `zero`=1, `err`=0, `busy`=0, `done`=0, state=IDLE, counter=0.
- Reset asserted mid-operation aborts the op immediately. No `done` is produced and all outputs take their reset values.
- Single-cycle op latency: `start` sampled at edge N; outputs valid and `done`=1 after edge N, for one cycle.
- Mul/div latency: `start` sampled at edge N.
  - `busy`=1 from edge N through edge N+WIDTH.
  - `done`=1 and results valid after edge N+WIDTH.
  - `busy`=0 in the same cycle that `done`=1.
- Back-to-back: `start` may be asserted in the cycle where `done`=1. It is accepted at the next edge, giving zero dead cycles.
- `busy` and `done` are never both driven by the same op past its completion edge. `done` never lasts more than one cycle per accepted `start`.

## Test plan
- Reset: assert `rst` asynchronously between edges. Required: all outputs go to reset values immediately, `zero`=1, `busy`=0.
- Add overflow (WIDTH=32): `a`=0x7FFFFFFF, `b`=1, add. Required after 1 cycle: `result`=0x80000000, `overflow`=1, `done`=1.
- Sub zero: sub with `a`=`b`=0x1234. Required: `result`=0, `zero`=1, `overflow`=0.
- Slt under overflow: `a`=0x80000000, `b`=1, slt. Required: `result`=1.
- Nand: `a`=0xF0F0F0F0, `b`=0xFF00FF00, nand. Required: `result`=0x0FFF0FFF.
- Mul: `a`=0xFFFFFFFF, `b`=0xFFFFFFFF. Required: `busy` for 32 cycles, `done` at edge N+32, `result_hi`=0xFFFFFFFE, `result`=0x00000001. A `start` pulse mid-op must be ignored.
- Div: `a`=100, `b`=7. Required: `result`=14, `result_hi`=2, `err`=0.
- Divide by zero: `b`=0. Required: `result`=0xFFFFFFFF, `result_hi`=`a`, `err`=1, latency 32.
- Reset mid-multiply: assert `rst` at cycle 10 of a mul. Required: no `done`, outputs at reset values. A new add started after reset completes normally.
